// File: rtl/edge_detect_filtered_pkg.sv
// edge_detect_filtered_pkg
//   Shared helpers for the filtered multi-channel edge detector:
//   counter width calculation and parameter range checking.
//   Optional feature macro (see edge_filter_channel): EDGE_DETECT_FILTERED_STICKY_EN.
package edge_detect_filtered_pkg;

  // Width of a counter that must hold 0 .. cycles-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((64'd1 << w) >= 64'(cycles)) return w;
    end
    return 32;
  endfunction

  function automatic bit params_valid(input int unsigned nr_bits,
                                      input int unsigned filter_cycles,
                                      input int unsigned reset_level);
    return (nr_bits >= 1) && (filter_cycles >= 1) && (reset_level <= 1);
  endfunction

endpackage

// File: rtl/edge_detect_filtered_if.sv
// edge_detect_filtered_if
//   Channel bundle between the pin side and the edge detector.
//   signal, clear          : driven by master (pin/control side)
//   level, rising, falling,
//   rising_sticky,
//   falling_sticky         : driven by slave (edge_detect_filtered)
interface edge_detect_filtered_if #(
  parameter int unsigned NR_BITS = 1
);
  logic [NR_BITS-1:0] signal;
  logic [NR_BITS-1:0] clear;
  logic [NR_BITS-1:0] level;
  logic [NR_BITS-1:0] rising;
  logic [NR_BITS-1:0] falling;
  logic [NR_BITS-1:0] rising_sticky;
  logic [NR_BITS-1:0] falling_sticky;

  modport master (
    output signal, clear,
    input  level, rising, falling, rising_sticky, falling_sticky
  );

  modport slave (
    input  signal, clear,
    output level, rising, falling, rising_sticky, falling_sticky
  );
endinterface

// File: rtl/edge_detect_filtered_channel.sv
// edge_filter_channel
//   One channel: synchroniser chain, glitch filter, level and edge pulse
//   registers, optional sticky flags.
//   Ports: clk, n_reset (async active-low), signal (raw, async),
//          clear (sticky clear), level, rising, falling,
//          rising_sticky, falling_sticky.
//   Macro EDGE_DETECT_FILTERED_STICKY_EN enables the sticky flag registers;
//   otherwise the sticky outputs are tied low and clear is ignored.
module edge_filter_channel
  import edge_detect_filtered_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic signal,
  input  logic clear,
  output logic level,
  output logic rising,
  output logic falling,
  output logic rising_sticky,
  output logic falling_sticky
);

  localparam int unsigned CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync;
  logic [CW-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync = signal;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      // Shift form keeps the single-stage case free of zero-width slices.
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) chain <= {SYNC_STAGES{RESET_LEVEL}};
        else          chain <= (chain << 1) | SYNC_STAGES'(signal);
      end
      assign sync = chain[SYNC_STAGES-1];
    end
  endgenerate

  // A change is accepted only after FILTER_CYCLES consecutive samples that
  // differ from the current level; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt     <= '0;
      level   <= RESET_LEVEL;
      rising  <= 1'b0;
      falling <= 1'b0;
    end else begin
      rising  <= 1'b0;
      falling <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        level   <= sync;
        rising  <= sync;
        falling <= ~sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef EDGE_DETECT_FILTERED_STICKY_EN
  // Set has priority over clear so a pulse arriving with clear is not lost.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rising_sticky  <= 1'b0;
      falling_sticky <= 1'b0;
    end else begin
      if (rising)     rising_sticky <= 1'b1;
      else if (clear) rising_sticky <= 1'b0;
      if (falling)    falling_sticky <= 1'b1;
      else if (clear) falling_sticky <= 1'b0;
    end
  end
`else
  logic unused_clear;
  assign unused_clear   = clear;
  assign rising_sticky  = 1'b0;
  assign falling_sticky = 1'b0;
`endif

endmodule

// File: rtl/edge_detect_filtered.sv
// edge_detect_filtered
//   Multi-channel synchronised, debounced edge detector.
//   Ports: clk, n_reset (async active-low),
//          bus (edge_detect_filtered_if.slave): signal, clear in;
//          level, rising, falling, rising_sticky, falling_sticky out.
//   Parameters: NR_BITS, SYNC_STAGES, FILTER_CYCLES, RESET_LEVEL.
//   Macro EDGE_DETECT_FILTERED_STICKY_EN enables the sticky edge flags.
module edge_detect_filtered
  import edge_detect_filtered_pkg::*;
#(
  parameter int unsigned NR_BITS       = 1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter int unsigned RESET_LEVEL   = 0
) (
  input  logic                   clk,
  input  logic                   n_reset,
  edge_detect_filtered_if.slave  bus
);

  generate
    if (!params_valid(NR_BITS, FILTER_CYCLES, RESET_LEVEL)) begin : g_bad_params
      $error("edge_detect_filtered: NR_BITS>=1, FILTER_CYCLES>=1, RESET_LEVEL in {0,1}");
    end
  endgenerate

  for (genvar i = 0; i < NR_BITS; i++) begin : g_ch
    edge_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_LEVEL  (1'(RESET_LEVEL))
    ) u_ch (
      .clk           (clk),
      .n_reset       (n_reset),
      .signal        (bus.signal[i]),
      .clear         (bus.clear[i]),
      .level         (bus.level[i]),
      .rising        (bus.rising[i]),
      .falling       (bus.falling[i]),
      .rising_sticky (bus.rising_sticky[i]),
      .falling_sticky(bus.falling_sticky[i])
    );
  end

endmodule

// File: tb/tb_edge_detect_filtered.sv
module tb_edge_detect_filtered;

  localparam int NI = 4;
  localparam int P_NB[NI] = '{4, 4, 1, 2};
  localparam int P_S [NI] = '{2, 2, 2, 0};
  localparam int P_F [NI] = '{4, 1, 1, 3};
  localparam int P_RL[NI] = '{0, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_reset;

  logic [3:0] sig[NI];
  logic [3:0] clr[NI];
  logic [3:0] o_lvl[NI], o_r[NI], o_f[NI], o_rs[NI], o_fs[NI];

  edge_detect_filtered_if #(.NR_BITS(4)) if0 ();
  edge_detect_filtered_if #(.NR_BITS(4)) if1 ();
  edge_detect_filtered_if #(.NR_BITS(1)) if2 ();
  edge_detect_filtered_if #(.NR_BITS(2)) if3 ();

  assign if0.signal = sig[0];       assign if0.clear = clr[0];
  assign if1.signal = sig[1];       assign if1.clear = clr[1];
  assign if2.signal = sig[2][0];    assign if2.clear = clr[2][0];
  assign if3.signal = sig[3][1:0];  assign if3.clear = clr[3][1:0];

  assign o_lvl[0] = if0.level;  assign o_r[0] = if0.rising;  assign o_f[0] = if0.falling;
  assign o_rs[0]  = if0.rising_sticky;  assign o_fs[0] = if0.falling_sticky;
  assign o_lvl[1] = if1.level;  assign o_r[1] = if1.rising;  assign o_f[1] = if1.falling;
  assign o_rs[1]  = if1.rising_sticky;  assign o_fs[1] = if1.falling_sticky;
  assign o_lvl[2] = {3'b0, if2.level};  assign o_r[2] = {3'b0, if2.rising};
  assign o_f[2]   = {3'b0, if2.falling};
  assign o_rs[2]  = {3'b0, if2.rising_sticky};  assign o_fs[2] = {3'b0, if2.falling_sticky};
  assign o_lvl[3] = {2'b0, if3.level};  assign o_r[3] = {2'b0, if3.rising};
  assign o_f[3]   = {2'b0, if3.falling};
  assign o_rs[3]  = {2'b0, if3.rising_sticky};  assign o_fs[3] = {2'b0, if3.falling_sticky};

  edge_detect_filtered #(.NR_BITS(P_NB[0]), .SYNC_STAGES(P_S[0]), .FILTER_CYCLES(P_F[0]),
                         .RESET_LEVEL(P_RL[0]))
    u0 (.clk(clk), .n_reset(n_reset), .bus(if0));
  edge_detect_filtered #(.NR_BITS(P_NB[1]), .SYNC_STAGES(P_S[1]), .FILTER_CYCLES(P_F[1]),
                         .RESET_LEVEL(P_RL[1]))
    u1 (.clk(clk), .n_reset(n_reset), .bus(if1));
  edge_detect_filtered #(.NR_BITS(P_NB[2]), .SYNC_STAGES(P_S[2]), .FILTER_CYCLES(P_F[2]),
                         .RESET_LEVEL(P_RL[2]))
    u2 (.clk(clk), .n_reset(n_reset), .bus(if2));
  edge_detect_filtered #(.NR_BITS(P_NB[3]), .SYNC_STAGES(P_S[3]), .FILTER_CYCLES(P_F[3]),
                         .RESET_LEVEL(P_RL[3]))
    u3 (.clk(clk), .n_reset(n_reset), .bus(if3));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: a raw-sample delay line stands in for the synchroniser,
  // and a window of the sync samples seen since the last accepted change
  // decides acceptance (full window, every sample opposite to the level).
  bit m_delay[NI][4][$];
  bit m_win[NI][4][$];
  bit m_lvl[NI][4], m_r[NI][4], m_f[NI][4], m_rs[NI][4], m_fs[NI][4];

  function automatic void model_reset();
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < 4; c++) begin
        m_delay[k][c].delete();
        repeat (P_S[k]) m_delay[k][c].push_back(P_RL[k][0]);
        m_win[k][c].delete();
        m_lvl[k][c] = (c < P_NB[k]) ? P_RL[k][0] : 1'b0;
        m_r[k][c] = 0; m_f[k][c] = 0; m_rs[k][c] = 0; m_fs[k][c] = 0;
      end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < P_NB[k]; c++) begin
        bit s, acc;
        if (P_S[k] == 0) s = sig[k][c];
        else begin
          s = m_delay[k][c].pop_front();
          m_delay[k][c].push_back(sig[k][c]);
        end
        m_rs[k][c] = m_r[k][c] ? 1'b1 : (clr[k][c] ? 1'b0 : m_rs[k][c]);
        m_fs[k][c] = m_f[k][c] ? 1'b1 : (clr[k][c] ? 1'b0 : m_fs[k][c]);
        m_win[k][c].push_back(s);
        if (m_win[k][c].size() > P_F[k]) void'(m_win[k][c].pop_front());
        acc = (m_win[k][c].size() == P_F[k]);
        for (int j = 0; j < m_win[k][c].size(); j++)
          if (m_win[k][c][j] == m_lvl[k][c]) acc = 0;
        if (acc) begin
          m_lvl[k][c] = s; m_r[k][c] = s; m_f[k][c] = !s;
          m_win[k][c].delete();
        end else begin
          m_r[k][c] = 0; m_f[k][c] = 0;
        end
      end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      logic [3:0] el, er, ef, ers, efs;
      for (int c = 0; c < 4; c++) begin
        el[c] = m_lvl[k][c]; er[c] = m_r[k][c]; ef[c] = m_f[k][c];
`ifdef EDGE_DETECT_FILTERED_STICKY_EN
        ers[c] = m_rs[k][c]; efs[c] = m_fs[k][c];
`else
        ers[c] = 1'b0; efs[c] = 1'b0;
`endif
      end
      check($sformatf("model.u%0d.level", k), {4'b0, o_lvl[k]}, {4'b0, el});
      check($sformatf("model.u%0d.rising", k), {4'b0, o_r[k]}, {4'b0, er});
      check($sformatf("model.u%0d.falling", k), {4'b0, o_f[k]}, {4'b0, ef});
      check($sformatf("model.u%0d.rising_sticky", k), {4'b0, o_rs[k]}, {4'b0, ers});
      check($sformatf("model.u%0d.falling_sticky", k), {4'b0, o_fs[k]}, {4'b0, efs});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (!n_reset) model_reset();
    else model_step();
    compare_all();
  endtask

  task automatic assert_reset();
    n_reset = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  // Drive u0 channel 0 high for high_ticks samples, then low; count rising pulses.
  task automatic pulse_u0(input int high_ticks, output int r_cnt, output int first_at);
    r_cnt = 0; first_at = 0;
    sig[0][0] = 1'b1;
    for (int t = 1; t <= high_ticks + 10; t++) begin
      tick();
      if (o_r[0][0]) begin
        r_cnt++;
        if (first_at == 0) first_at = t;
      end
      if (t == high_ticks) sig[0][0] = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] sig;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, fa;
    // u1: SYNC_STAGES=2, FILTER_CYCLES=1 -> outputs follow signal two samples late
    tbl[0] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
    tbl[2] = '{4'b1010, 4'b0101, 4'b0101, 4'b0000};
    tbl[3] = '{4'b1010, 4'b1010, 4'b1010, 4'b0101};
    tbl[4] = '{4'b1111, 4'b1010, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0000, 4'b1010, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0000, 4'b1111, 4'b0101, 4'b0000};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

    for (int k = 0; k < NI; k++) begin sig[k] = '0; clr[k] = '0; end
    n_reset = 1'b1;
    #2;
    assert_reset();
    check("reset.u0.level", {4'b0, o_lvl[0]}, 8'h00);
    check("reset.u2.level_rl1", {4'b0, o_lvl[2]}, 8'h01);
    check("reset.u1.edges", {o_r[1], o_f[1]}, 8'h00);
    tick();
    tick();
    n_reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      sig[1] = tbl[i].sig;
      tick();
      check($sformatf("tbl[%0d].level", i), {4'b0, o_lvl[1]}, {4'b0, tbl[i].lvl});
      check($sformatf("tbl[%0d].rising", i), {4'b0, o_r[1]}, {4'b0, tbl[i].rise});
      check($sformatf("tbl[%0d].falling", i), {4'b0, o_f[1]}, {4'b0, tbl[i].fall});
      check($sformatf("rl1.falling[%0d]", i), {4'b0, o_f[2]}, (i == 2) ? 8'h01 : 8'h00);
      check($sformatf("rl1.level[%0d]", i), {4'b0, o_lvl[2]}, (i >= 2) ? 8'h00 : 8'h01);
    end

    pulse_u0(3, rc, fa);
    check("glitch3.rises", 8'(rc), 8'd0);
    pulse_u0(4, rc, fa);
    check("pulse4.rises", 8'(rc), 8'd1);
    check("pulse4.first_at", 8'(fa), 8'd6);
    check("pulse4.level_end", {4'b0, o_lvl[0]}, 8'h00);

    sig[0][0] = 1'b1;
    sig[1] = 4'hF;
    repeat (4) tick();
    check("midreset.u1.level_pre", {4'b0, o_lvl[1]}, 8'h0F);
    assert_reset();
    check("midreset.u1.level_now", {4'b0, o_lvl[1]}, 8'h00);
    check("midreset.u0.edges_now", {o_r[0], o_f[0]}, 8'h00);
    tick();
    n_reset = 1'b1;
    pulse_u0(3, rc, fa);
    check("midreset.requal3.rises", 8'(rc), 8'd0);
    pulse_u0(4, rc, fa);
    check("midreset.requal4.rises", 8'(rc), 8'd1);
    check("midreset.requal4.first_at", 8'(fa), 8'd6);

`ifdef EDGE_DETECT_FILTERED_STICKY_EN
    sig[1] = 4'h0; clr[1] = 4'hF;
    repeat (6) tick();
    clr[1] = 4'h0;
    sig[1] = 4'b0001;
    repeat (3) tick();
    check("sticky.rise_pulse", {4'b0, o_r[1]}, 8'h01);
    tick();
    check("sticky.set", {4'b0, o_rs[1]}, 8'h01);
    repeat (3) tick();
    check("sticky.hold", {4'b0, o_rs[1]}, 8'h01);
    clr[1] = 4'b0001;
    tick();
    check("sticky.clear", {4'b0, o_rs[1]}, 8'h00);
    clr[1] = 4'h0;
    sig[1] = 4'h0;
    repeat (4) tick();
    check("sticky.fall_set", {4'b0, o_fs[1]}, 8'h01);
    sig[1] = 4'b0001;
    repeat (3) tick();
    check("sticky.rise_pulse2", {4'b0, o_r[1]}, 8'h01);
    clr[1] = 4'b0001;
    tick();
    check("sticky.set_beats_clear", {4'b0, o_rs[1]}, 8'h01);
    clr[1] = 4'h0;
    tick();
    check("sticky.hold2", {4'b0, o_rs[1]}, 8'h01);
    clr[1] = 4'b0001;
    tick();
    check("sticky.clear2", {4'b0, o_rs[1]}, 8'h00);
    clr[1] = 4'h0;
`endif

    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NI; k++) begin
        for (int c = 0; c < 4; c++)
          if ($urandom_range(0, 4) == 0) sig[k][c] = ~sig[k][c];
        clr[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        tick();
        n_reset = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
